// File: rtl/cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl
//
// Generates the XM23 CPU execution clock (cpu_clk) from the 50 MHz board clock.
// Two modes:
//   * single-step: one full cpu_clk period per debounced KEY[0] press
//   * continuous run: back-to-back periods, halting at the hardware breakpoint
//     or when the core sets the PSW SLP bit
// Once a period has started it always completes, so cpu_clk never carries a
// truncated pulse.
//
// Optional feature (compile-time macro CPU_CLOCK_STEP_COUNTER_EN):
//   defined   -> step_count counts completed cpu_clk periods (wraps, cleared
//                by Reset)
//   undefined -> no counter logic, step_count is tied to 0
//
// Ports:
//   Clock           board clock, all state changes on its rising edge
//   Reset           synchronous, active-high reset
//   key_step_n      raw KEY[0] level, active low, asynchronous to Clock
//   run_mode        1 = continuous run, 0 = single-step
//   bkpt_en         1 = breakpoint compare armed
//   breakpnt[15:0]  breakpoint address
//   PC[15:0]        current R7 from the core
//   slp             PSW SLP bit from the core
//   instr_boundary  core sits at an instruction-fetch boundary
//   cpu_clk         generated CPU clock (registered)
//   running         high in RUN
//   bkpt_hit        high in BKPT
//   step_count[31:0] completed cpu_clk periods (see macro above)
// -----------------------------------------------------------------------------
module cpu_clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HALF_PERIOD     = 25,
    parameter int DB_W            = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        key_step_n,
    input  logic        run_mode,
    input  logic        bkpt_en,
    input  logic [15:0] breakpnt,
    input  logic [15:0] PC,
    input  logic        slp,
    input  logic        instr_boundary,
    output logic        cpu_clk,
    output logic        running,
    output logic        bkpt_hit,
    output logic [31:0] step_count
);

    localparam int HC_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_STEP     = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_BKPT     = 3'd3;
    localparam logic [2:0] S_STEP_OUT = 3'd4;

    // Key synchroniser and debouncer (key levels are active low: 1 = released)
    logic            key_meta_q, key_meta_d;
    logic            key_sync_q, key_sync_d;
    logic            key_acc_q,  key_acc_d;
    logic [DB_W-1:0] db_cnt_q,   db_cnt_d;
    logic            step_req_q, step_req_d;

    // Period generator and state machine
    logic [2:0]      state_q,    state_d;
    logic            cpu_clk_q,  cpu_clk_d;
    logic [HC_W-1:0] half_cnt_q, half_cnt_d;

    logic active;
    logic half_last;
    logic period_end;
    logic bkpt_match;
    logic start_period;

    always_comb begin
        key_meta_d = key_step_n;
        key_sync_d = key_meta_q;
    end

    // The accepted level only flips after DEBOUNCE_CYCLES consecutive samples
    // that disagree with it; any agreeing sample restarts the count.
    always_comb begin
        key_acc_d  = key_acc_q;
        db_cnt_d   = db_cnt_q;
        step_req_d = 1'b0;
        if (key_sync_q == key_acc_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            key_acc_d  = key_sync_q;
            db_cnt_d   = '0;
            step_req_d = ~key_sync_q;   // only released-to-pressed requests a step
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign active     = (state_q == S_STEP) || (state_q == S_RUN) || (state_q == S_STEP_OUT);
    assign half_last  = (half_cnt_q == HC_LAST);
    assign period_end = active && !cpu_clk_q && half_last;
    assign bkpt_match = bkpt_en && instr_boundary && (PC == breakpnt);

    always_comb begin
        state_d      = state_q;
        start_period = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (step_req_q) begin
                    state_d      = S_STEP;
                    start_period = 1'b1;
                end else if (run_mode && !slp) begin
                    state_d      = S_RUN;
                    start_period = 1'b1;
                end
            end
            S_STEP: begin
                if (period_end) state_d = S_IDLE;
            end
            S_RUN: begin
                if (period_end) begin
                    if (!run_mode || slp) begin
                        state_d = S_IDLE;
                    end else if (bkpt_match) begin
                        state_d = S_BKPT;
                    end else begin
                        start_period = 1'b1;
                    end
                end
            end
            S_BKPT: begin
                if (step_req_q) begin
                    state_d      = S_STEP_OUT;
                    start_period = 1'b1;
                end else if (!run_mode) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP_OUT: begin
                // No breakpoint compare here: the core must be allowed to
                // move off the breakpoint PC.
                if (period_end) begin
                    if (run_mode && !slp) begin
                        state_d      = S_RUN;
                        start_period = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A period is HALF_PERIOD cycles high followed by HALF_PERIOD cycles low.
    // Starting a period raises cpu_clk on the very next edge.
    always_comb begin
        cpu_clk_d  = 1'b0;
        half_cnt_d = '0;
        if (start_period) begin
            cpu_clk_d  = 1'b1;
            half_cnt_d = '0;
        end else if (active && !period_end) begin
            cpu_clk_d = cpu_clk_q;
            if (half_last) begin
                cpu_clk_d  = 1'b0;
                half_cnt_d = '0;
            end else begin
                half_cnt_d = half_cnt_q + HC_W'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            key_acc_q  <= 1'b1;
            db_cnt_q   <= '0;
            step_req_q <= 1'b0;
            state_q    <= S_IDLE;
            cpu_clk_q  <= 1'b0;
            half_cnt_q <= '0;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            key_acc_q  <= key_acc_d;
            db_cnt_q   <= db_cnt_d;
            step_req_q <= step_req_d;
            state_q    <= state_d;
            cpu_clk_q  <= cpu_clk_d;
            half_cnt_q <= half_cnt_d;
        end
    end

`ifdef CPU_CLOCK_STEP_COUNTER_EN
    logic [31:0] step_cnt_q, step_cnt_d;

    always_comb begin
        step_cnt_d = step_cnt_q + 32'(period_end);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    assign step_count = step_cnt_q;
`else
    assign step_count = '0;
`endif

    assign cpu_clk  = cpu_clk_q;
    assign running  = (state_q == S_RUN);
    assign bkpt_hit = (state_q == S_BKPT);

endmodule
